alu_control_unit: RTL

- Hardwired control sequencer that drives the datapath's control inputs (register enables, bus-source select, memory read, ALU op).
- Replaces hand-sequenced stimulus as the initiator side of the datapath control interface.
- Fetches an instruction, then executes one three-register ALU instruction ("op Ra, Rb, Rc": Ra <- Rb op Rc) in states T0..T5.
- Runs continuously while run is high.

---
 rtl/cu_pkg.sv | 44 ++++
 rtl/alu_control_unit_if.sv | 33 +++
 rtl/cu_opcode_decode.sv | 43 ++++
 rtl/alu_control_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared states, bus bit map, opcodes and ALU codes for the control unit
package cu_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } cu_state_e;

    // Bit positions shared by enable and busSelect; R0-R15 occupy bits 0-15
    localparam int BIT_ZLO = 19;
    localparam int BIT_PC  = 20;
    localparam int BIT_MDR = 21;
    localparam int BIT_MAR = 22;
    localparam int BIT_IR  = 23;
    localparam int BIT_Z   = 24;
    localparam int BIT_Y   = 27;

    localparam int OPC_W      = 5;
    localparam int REG_IDX_W  = 4;
    localparam int ALU_CODE_W = 4;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

    localparam logic [ALU_CODE_W-1:0] ALU_NOP = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_SHR = 4'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_SHL = 4'd8;

endpackage

// File: rtl/alu_control_unit_if.sv
// rtl/alu_control_unit_if.sv - datapath control interface between sequencer and datapath
interface alu_control_unit_if #(
    parameter int WORD_W   = 32,
    parameter int ALU_OP_W = 4
);
    logic [WORD_W-1:0]   ir;
    logic                mem_ready;
    logic [WORD_W-1:0]   enable;
    logic [WORD_W-1:0]   busSelect;
    logic                MR_Read;
    logic                inc_pc;
    logic [ALU_OP_W-1:0] Control_Signals;

    modport master (
        input  ir,
        input  mem_ready,
        output enable,
        output busSelect,
        output MR_Read,
        output inc_pc,
        output Control_Signals
    );

    modport slave (
        output ir,
        output mem_ready,
        input  enable,
        input  busSelect,
        input  MR_Read,
        input  inc_pc,
        input  Control_Signals
    );
endinterface

// File: rtl/cu_opcode_decode.sv
// rtl/cu_opcode_decode.sv - combinational IR decode into ALU code, legality and register fields
module cu_opcode_decode
    import cu_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0]     ir,
    output logic [ALU_CODE_W-1:0] alu_op,
    output logic                  legal,
    output logic                  is_halt,
    output logic [REG_IDX_W-1:0]  ra,
    output logic [REG_IDX_W-1:0]  rb,
    output logic [REG_IDX_W-1:0]  rc
);
    logic [OPC_W-1:0] opcode;
    logic             unused_ir_low;

    assign opcode        = ir[31:27];
    assign ra            = ir[26:23];
    assign rb            = ir[22:19];
    assign rc            = ir[18:15];
    assign unused_ir_low = ^ir[14:0];

    // legal means "executes as an ALU op"; HALT is reported separately
    always_comb begin
        alu_op  = ALU_NOP;
        legal   = 1'b1;
        is_halt = 1'b0;
        case (opcode)
            OPC_ADD:  alu_op = ALU_ADD;
            OPC_SUB:  alu_op = ALU_SUB;
            OPC_AND:  alu_op = ALU_AND;
            OPC_OR:   alu_op = ALU_OR;
            OPC_SHR:  alu_op = ALU_SHR;
            OPC_SHL:  alu_op = ALU_SHL;
            OPC_HALT: begin
                legal   = 1'b0;
                is_halt = 1'b1;
            end
            default:  legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - fetch/execute control sequencer; CU_STEP_EN adds single-step input
module alu_control_unit
    import cu_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
`ifdef CU_STEP_EN
    input  logic                step,
`endif
    alu_control_unit_if.master  cu,
    output logic                done,
    output logic                halted,
    output logic                fault
);
    localparam logic [WORD_W-1:0] ONE = {{(WORD_W-1){1'b0}}, 1'b1};

    cu_state_e              state;
    cu_state_e              state_nx;
    logic                   fault_q;
    logic                   start_ok;
    logic [ALU_CODE_W-1:0]  alu_op;
    logic                   legal;
    logic                   is_halt;
    logic [REG_IDX_W-1:0]   ra;
    logic [REG_IDX_W-1:0]   rb;
    logic [REG_IDX_W-1:0]   rc;

    cu_opcode_decode #(.WORD_W(WORD_W)) u_decode (
        .ir      (cu.ir),
        .alu_op  (alu_op),
        .legal   (legal),
        .is_halt (is_halt),
        .ra      (ra),
        .rb      (rb),
        .rc      (rc)
    );

`ifdef CU_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign start_ok = run & step & ~step_q;
`else
    assign start_ok = run;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= S_IDLE;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_T3 && !legal && !is_halt) begin
                fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_ok) state_nx = S_T0;
            S_T0:   state_nx = S_T1;
            S_T1:   if (cu.mem_ready) state_nx = S_T2;
            S_T2:   state_nx = S_T3;
            S_T3:   state_nx = legal ? S_T4 : S_HALT;
            S_T4:   state_nx = S_T5;
`ifdef CU_STEP_EN
            S_T5:   state_nx = S_IDLE;
`else
            S_T5:   state_nx = run ? S_T0 : S_IDLE;
`endif
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs depend only on state (and decoded ir fields), so clr clears them without a clock
    always_comb begin
        cu.enable          = '0;
        cu.busSelect       = '0;
        cu.MR_Read         = 1'b0;
        cu.inc_pc          = 1'b0;
        cu.Control_Signals = '0;
        done               = 1'b0;
        case (state)
            S_T0: begin
                cu.busSelect = ONE << BIT_PC;
                cu.enable    = (ONE << BIT_MAR) | (ONE << BIT_PC);
                cu.inc_pc    = 1'b1;
            end
            S_T1: begin
                cu.MR_Read = 1'b1;
                cu.enable  = ONE << BIT_MDR;
            end
            S_T2: begin
                cu.busSelect = ONE << BIT_MDR;
                cu.enable    = ONE << BIT_IR;
            end
            S_T3: begin
                if (legal) begin
                    cu.busSelect = ONE << rb;
                    cu.enable    = ONE << BIT_Y;
                end
            end
            S_T4: begin
                cu.busSelect       = ONE << rc;
                cu.enable          = ONE << BIT_Z;
                cu.Control_Signals = ALU_OP_W'(alu_op);
            end
            S_T5: begin
                cu.busSelect = ONE << BIT_ZLO;
                cu.enable    = ONE << ra;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted = (state == S_HALT);
    assign fault  = fault_q;

endmodule
